// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: RF operand read with write-through bypass, 1-entry RAW scoreboard, load/store FSM.
// Datapath drive registered (ALU result written back 2 cycles after accept); instr_ready drops on RAW hazard or outstanding load.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] aluin1,
    output logic [31:0] aluin2,
    output logic [2:0]  operation_out,
    output logic [2:0]  opselect_out,
    output logic [4:0]  shift_number,
    output logic        enable_arith,
    output logic        enable_shift,
    input  logic [31:0] aluout,
    output logic        mem_rd_req,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic {S_RUN, S_WAIT_MEM} state_t;

    state_t      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [4:0]  pend_dest_q, pend_dest_d;
    logic        wb_vld_q, wb_vld_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        ld_wb_q, ld_wb_d;
    logic [4:0]  ld_dest_q, ld_dest_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [31:0] ld_dat_q, ld_dat_d;
    logic [31:0] aluin1_q, aluin1_d, aluin2_q, aluin2_d;
    logic [2:0]  op_q, op_d, opsel_q, opsel_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        en_arith_q, en_arith_d, en_shift_q, en_shift_d;
    logic        rd_req_q, rd_req_d, wr_en_q, wr_en_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

    logic [2:0]  f_opsel, f_op;
    logic [4:0]  f_dest, f_src1, f_src2, f_shamt;
    logic [31:0] imm_sx, opnd1, opnd2;
    logic        is_shift, is_arith, is_arithi, is_store, is_load, is_alu;
    logic        uses1, uses2, hazard, accept;

    assign f_opsel = instr[31:29];
    assign f_op    = instr[28:26];
    assign f_dest  = instr[25:21];
    assign f_src1  = instr[20:16];
    assign f_src2  = instr[15:11];
    assign f_shamt = instr[10:6];
    assign imm_sx  = {{16{instr[15]}}, instr[15:0]};

    assign is_shift  = (f_opsel == 3'b000);
    assign is_arith  = (f_opsel == 3'b001);
    assign is_arithi = (f_opsel == 3'b011);
    assign is_store  = (f_opsel == 3'b100);
    assign is_load   = (f_opsel == 3'b101);
    assign is_alu    = is_shift | is_arith | is_arithi;
    assign uses1     = is_alu | is_store | is_load;
    assign uses2     = is_arith | is_store;

    assign rf_raddr1 = RESET ? f_src1 : 5'd0;
    assign rf_raddr2 = RESET ? f_src2 : 5'd0;

    // Writeback of either source; waddr is never 0 while rf_we is high.
    assign rf_we    = wb_vld_q | ld_wb_q;
    assign rf_waddr = ld_wb_q ? ld_dest_q : (wb_vld_q ? wb_dest_q : 5'd0);
    assign rf_wdata = ld_wb_q ? ld_dat_q : (wb_vld_q ? aluout : 32'd0);

    assign opnd1 = (f_src1 == 5'd0) ? 32'd0 :
                   (rf_we && rf_waddr == f_src1) ? rf_wdata : rf_rdata1;
    assign opnd2 = (f_src2 == 5'd0) ? 32'd0 :
                   (rf_we && rf_waddr == f_src2) ? rf_wdata : rf_rdata2;

    assign hazard = pend_vld_q && ((uses1 && pend_dest_q == f_src1) ||
                                   (uses2 && pend_dest_q == f_src2));
    assign instr_ready = RESET && (state_q == S_RUN) && !hazard;
    assign accept      = instr_valid && instr_ready;

    assign aluin1        = aluin1_q;
    assign aluin2        = aluin2_q;
    assign operation_out = op_q;
    assign opselect_out  = opsel_q;
    assign shift_number  = shamt_q;
    assign enable_arith  = en_arith_q;
    assign enable_shift  = en_shift_q;
    assign mem_rd_req    = rd_req_q;
    assign mem_wr_en     = wr_en_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

    function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b000:  fmt_load = {{24{d[7]}}, d[7:0]};
            3'b100:  fmt_load = {24'd0, d[7:0]};
            3'b001:  fmt_load = {{16{d[15]}}, d[15:0]};
            3'b101:  fmt_load = {16'd0, d[15:0]};
            default: fmt_load = d;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = 1'b0;
        pend_dest_d = pend_dest_q;
        // The only supported ALU latency makes the pending entry retire the very next cycle.
        wb_vld_d    = pend_vld_q && (ALU_LAT == 1);
        wb_dest_d   = pend_dest_q;
        ld_wb_d     = 1'b0;
        ld_dest_d   = ld_dest_q;
        ld_op_d     = ld_op_q;
        ld_dat_d    = ld_dat_q;
        aluin1_d    = aluin1_q;
        aluin2_d    = aluin2_q;
        op_d        = op_q;
        opsel_d     = opsel_q;
        shamt_d     = shamt_q;
        en_arith_d  = 1'b0;
        en_shift_d  = 1'b0;
        rd_req_d    = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_RUN: begin
                if (accept && is_alu) begin
                    en_shift_d  = is_shift;
                    en_arith_d  = is_arith | is_arithi;
                    aluin1_d    = opnd1;
                    aluin2_d    = is_arithi ? imm_sx : opnd2;
                    op_d        = f_op;
                    opsel_d     = is_arithi ? 3'b001 : f_opsel;
                    shamt_d     = f_shamt;
                    pend_vld_d  = (f_dest != 5'd0);
                    pend_dest_d = f_dest;
                end else if (accept && is_store) begin
                    wr_en_d = 1'b1;
                    addr_d  = opnd1 + imm_sx;
                    wdata_d = opnd2;
                end else if (accept && is_load) begin
                    rd_req_d  = 1'b1;
                    addr_d    = opnd1 + imm_sx;
                    ld_dest_d = f_dest;
                    ld_op_d   = f_op;
                    state_d   = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rd_valid) begin
                    ld_wb_d  = (ld_dest_q != 5'd0);
                    ld_dat_d = fmt_load(ld_op_q, mem_rd_data);
                    state_d  = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_RUN;
            pend_vld_q  <= 1'b0;
            pend_dest_q <= 5'd0;
            wb_vld_q    <= 1'b0;
            wb_dest_q   <= 5'd0;
            ld_wb_q     <= 1'b0;
            ld_dest_q   <= 5'd0;
            ld_op_q     <= 3'd0;
            ld_dat_q    <= 32'd0;
            aluin1_q    <= 32'd0;
            aluin2_q    <= 32'd0;
            op_q        <= 3'd0;
            opsel_q     <= 3'd0;
            shamt_q     <= 5'd0;
            en_arith_q  <= 1'b0;
            en_shift_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_dest_q <= pend_dest_d;
            wb_vld_q    <= wb_vld_d;
            wb_dest_q   <= wb_dest_d;
            ld_wb_q     <= ld_wb_d;
            ld_dest_q   <= ld_dest_d;
            ld_op_q     <= ld_op_d;
            ld_dat_q    <= ld_dat_d;
            aluin1_q    <= aluin1_d;
            aluin2_q    <= aluin2_d;
            op_q        <= op_d;
            opsel_q     <= opsel_d;
            shamt_q     <= shamt_d;
            en_arith_q  <= en_arith_d;
            en_shift_q  <= en_shift_d;
            rd_req_q    <= rd_req_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and sequencing controller for the execute stage. It accepts 32-bit instructions over a valid/ready handshake, reads operands from the register file, and drives the execute datapath (`aluin1`/`aluin2`, `operation_out`/`opselect_out`, `shift_number`, `enable_arith`/`enable_shift`). It commits `aluout` back to the register file, stalls on read-after-write hazards, and runs load/store transactions through a small FSM.

## Interface
- `ALU_LAT`, 1: cycles from enable asserted to `aluout` valid; only value 1 is supported.
- `CLOCK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction present.
- `instr` in 32: instruction fields:
  - [31:29] opselect: 000 shift, 001 arith, 011 arith-immediate, 100 store, 101 load.
  - [28:26] operation.
  - [25:21] dest.
  - [20:16] src1.
  - [15:11] src2.
  - [10:6] shamt.
  - [15:0] imm, sign-extended.
- `instr_ready` out 1: instruction accepted when high with `instr_valid`.
- `rf_raddr1`, `rf_raddr2` out 5: combinational read addresses.
- `rf_rdata1`, `rf_rdata2` in 32: combinational read data.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: writeback port.
- `aluin1`, `aluin2` out 32; `operation_out`, `opselect_out` out 3; `shift_number` out 5; `enable_arith`, `enable_shift` out 1: datapath drive, all registered.
- `aluout` in 32: datapath result.
- `mem_rd_req` out 1, `mem_wr_en` out 1, `mem_addr` out 32, `mem_wdata` out 32: memory request.
- `mem_rd_valid` in 1, `mem_rd_data` in 32: memory read response.

## Operation
- **Reset.** All outputs are 0, FSM is RUN, scoreboard is cleared, and `instr_ready` is 0 while `RESET` is low.
- **Operand read.** `rf_raddr1`=src1 and `rf_raddr2`=src2 from `instr`.
  - Write-through bypass: if `rf_we` is high and `rf_waddr` equals a read address (and is nonzero), the operand is `rf_wdata`.
  - Register 0 reads as 0 and is never written.
- **Decode on accept.**
  - Shift: `enable_shift`=1, `aluin1`=src1 value, `shift_number`=shamt.
  - Arith: `enable_arith`=1, `aluin2`=src2 value.
  - Arith-immediate: `enable_arith`=1, `aluin2`=sext(imm), and `opselect_out` is driven as 001.
  - `operation_out` is copied from the instruction for these ops.
- **Scoreboard.** A 1-entry pending register holds {valid, dest} for an issued ALU op with dest≠0.
  - `instr_ready` is 0 when a pending dest matches src1, or (op uses src2) matches src2.
  - Load/store always use src1. Store also uses src2.
- **Writeback.** One cycle after enable, `rf_we`=1, `rf_waddr`=pending dest, `rf_wdata`=`aluout`, and the pending entry clears.
- **FSM states.**
  - RUN: accepts when not stalled. Load → WAIT_MEM. Store issues in one cycle and stays in RUN.
  - WAIT_MEM: `instr_ready`=0 until `mem_rd_valid`, then writeback and return to RUN.
- **Load** (101):
  - `mem_rd_req` pulses for one cycle with `mem_addr`=src1 value + sext(imm).
  - The response is formatted by operation:
    - 000: sign-extended byte [7:0].
    - 100: zero-extended byte.
    - 001: sign-extended half [15:0].
    - 101: zero-extended half.
    - 011: full word.
    - Others: full word.
  - `rf_we` is asserted in the cycle after `mem_rd_valid`.
- **Store** (100): `mem_wr_en` pulses for one cycle, `mem_addr`=src1+sext(imm), `mem_wdata`=src2 value. No writeback.
- **Datapath idle.** During loads, stores and idle cycles, `enable_arith`=`enable_shift`=0.
- **Unused opselect** (010, 110, 111): accepted and treated as NOP. No enable, no writeback.
- **Address arithmetic** is 32-bit modulo; carry is ignored.

## Timing
- **Accept.** Cycle N (`instr_valid`&&`instr_ready`). Datapath outputs are registered at the N edge and valid in N+1. `aluout` is valid in N+2, and `rf_we` is high in N+2.
- **Throughput.** Independent ALU ops issue at 1/cycle.
- **Dependent op.** `instr_ready` is low in N+1 and the op is accepted in N+2 via write-through bypass. The penalty is 1 bubble.
- **Load latency.** `mem_rd_req` in N+1. If `mem_rd_valid` arrives in cycle M, `rf_we` is in M+1 and the next accept is earliest in M+1.
- **Early response.** `mem_rd_valid` in the same cycle as `mem_rd_req` is legal (M=N+1). A `mem_rd_valid` in RUN is ignored.
- **Simultaneous events.** A writeback from an older ALU op and the acceptance of an independent instruction in the same cycle are both allowed.
- **Reset mid-operation.** Asserting `RESET` in WAIT_MEM aborts immediately, with no writeback. After release the controller is in RUN with an empty scoreboard.
- **Stall hold.** `instr` is held stable by the sender while `instr_ready` is low.

## Test plan
- **Reset.** Hold `RESET` low for 3 cycles with `instr_valid`=1. Required: all outputs 0 and `instr_ready`=0. Release: `instr_ready`=1 in the next cycle.
- **Back-to-back ADDs.** Preload r1=5, r2=7, r3=1. Issue ADD r4=r1+r2, then ADD r5=r3+r3. Required: no stall; r4=12 at N+2 and r5=2 at N+3.
- **RAW stall.** ADD r4=r1+r2, then SUB r6=r4-r1. Required: `instr_ready`=0 for one cycle, `aluin1`=12 by bypass, r6=7.
- **Signed byte load.** LOADBYTE with memory returning 0x00000080 after a 3-cycle wait. Required: `rf_wdata`=0xFFFFFF80, `instr_ready` low until the writeback cycle.
- **Unsigned half load and store.** LOADHALFU with 0xABCD8001 → 0x00008001. Store with r2=0xDEADBEEF, r1=0x100, imm=−4. Required: `mem_addr`=0xFC and a one-cycle `mem_wr_en`.
- **Reset mid-load.** Assert `RESET` in WAIT_MEM, then deliver `mem_rd_valid` after release. Required: no `rf_we`, and the next ADD issues normally.
